// File: rtl/sp_ram_fifo_pkg.sv
// Shared constants and grant encoding for the single-port-RAM FIFO.
package sp_ram_fifo_pkg;
   localparam int RAM_RD_LAT = 2;
   localparam int OBUF_DEPTH = 4;

   typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} gnt_t;

   // Round-robin flag holds the side that wins the next conflict.
   localparam logic RR_WR = 1'b0;
   localparam logic RR_RD = 1'b1;
endpackage

// File: rtl/sp_ram_fifo_if.sv
// Producer/consumer streaming bus of the FIFO; master is the traffic side, slave the FIFO.
interface sp_ram_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 256
);
   import sp_ram_fifo_pkg::*;
   localparam int CNT_WIDTH = $clog2(DEPTH + OBUF_DEPTH + 1);

   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  rd_ready;
   logic [CNT_WIDTH-1:0]  count;

   modport master (output wr_data, wr_valid, rd_ready,
                   input  wr_ready, rd_data, rd_valid, count);
   modport slave  (input  wr_data, wr_valid, rd_ready,
                   output wr_ready, rd_data, rd_valid, count);
endinterface

// File: rtl/single_port_RAM.sv
// Single-port RAM with registered inputs and registered output: op in cycle c, read data during c+2.
// No backpressure; one op per cycle, contents are never reset.
module single_port_RAM #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 256,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         addr_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   output logic [DATA_WIDTH-1:0] dout_o
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  en_q, we_q;
   logic [AW-1:0]         addr_q;
   logic [DATA_WIDTH-1:0] din_q, dout_q;

   always_ff @(posedge clk) begin
      en_q   <= en_i;
      we_q   <= we_i;
      addr_q <= addr_i;
      din_q  <= din_i;
      if (en_q && we_q)  mem_q[addr_q] <= din_q;
      if (en_q && !we_q) dout_q <= mem_q[addr_q];
   end

   assign dout_o = dout_q;
endmodule

// File: rtl/sp_ram_fifo_obuf.sv
// Small register FIFO with first-word-fall-through head; push visible next cycle.
// No backpressure: the caller guarantees push only with a free slot and pop only when valid.
module sp_ram_fifo_obuf
   import sp_ram_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              push_i,
   input  logic [DATA_WIDTH-1:0]             push_dat_i,
   input  logic                              pop_i,
   output logic [DATA_WIDTH-1:0]             head_o,
   output logic                              vld_o,
   output logic [$clog2(OBUF_DEPTH+1)-1:0]   occ_o
);
   localparam int PW = $clog2(OBUF_DEPTH);
   localparam int OW = $clog2(OBUF_DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [OBUF_DEPTH];
   logic [PW-1:0]         wp_q, rp_q;
   logic [OW-1:0]         occ_q;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < OBUF_DEPTH; i++) mem_q[i] <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
         occ_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wp_q] <= push_dat_i;
            wp_q        <= inc(wp_q);
         end
         if (pop_i) rp_q <= inc(rp_q);
         case ({push_i, pop_i})
            2'b10:   occ_q <= occ_q + OW'(1);
            2'b01:   occ_q <= occ_q - OW'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign head_o = mem_q[rp_q];
   assign vld_o  = (occ_q != '0);
   assign occ_o  = occ_q;
endmodule

// File: rtl/sp_ram_fifo.sv
// FIFO on one single-port RAM with prefetch into an output buffer; empty write-to-read latency 4 cycles.
// Writes stall when RAM is full or when a read wins the port; reads prefetch only with output-buffer credit.
module sp_ram_fifo
   import sp_ram_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 256
) (
   input logic         clk,
   input logic         rst,
   sp_ram_fifo_if.slave bus
);
   localparam int LB_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_WIDTH = $clog2(DEPTH + OBUF_DEPTH + 1);
   localparam int RC_WIDTH  = $clog2(DEPTH + 1);
   localparam int OCC_WIDTH = $clog2(OBUF_DEPTH + 1);

   logic [LB_DEPTH-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [RC_WIDTH-1:0]   ram_cnt_q, ram_cnt_d;
   logic [RAM_RD_LAT-1:0] infl_q, infl_d;
   logic                  rr_q, rr_d;
   logic [OCC_WIDTH-1:0]  occ;
   logic [OCC_WIDTH:0]    pend;
   logic                  want_rd, want_wr, obuf_vld, pop;
   logic [DATA_WIDTH-1:0] ram_dout, obuf_head;
   gnt_t                  gnt;

   function automatic logic [LB_DEPTH-1:0] ptr_inc(input logic [LB_DEPTH-1:0] p);
      return (p == LB_DEPTH'(DEPTH - 1)) ? '0 : p + LB_DEPTH'(1);
   endfunction

   // Credit counts words already in the buffer plus reads still inside the RAM pipe.
   assign pend    = {1'b0, occ} + (OCC_WIDTH+1)'($countones(infl_q));
   assign want_rd = (ram_cnt_q != '0) && (pend < (OCC_WIDTH+1)'(OBUF_DEPTH));
   assign want_wr = bus.wr_valid && (ram_cnt_q != RC_WIDTH'(DEPTH));

   assign bus.wr_ready = !rst && (ram_cnt_q != RC_WIDTH'(DEPTH))
                         && !(want_rd && (!bus.wr_valid || rr_q == RR_RD));

   always_comb begin
      gnt  = GNT_NONE;
      rr_d = rr_q;
      if (rst) begin
         gnt = GNT_NONE;
      end else if (want_wr && want_rd) begin
         gnt  = (rr_q == RR_RD) ? GNT_RD : GNT_WR;
         rr_d = ~rr_q;
      end else if (want_wr) begin
         gnt = GNT_WR;
      end else if (want_rd) begin
         gnt = GNT_RD;
      end
   end

   always_comb begin
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      ram_cnt_d = ram_cnt_q;
      infl_d    = {infl_q[RAM_RD_LAT-2:0], (gnt == GNT_RD)};
      case (gnt)
         GNT_WR: begin
            wptr_d    = ptr_inc(wptr_q);
            ram_cnt_d = ram_cnt_q + RC_WIDTH'(1);
         end
         GNT_RD: begin
            rptr_d    = ptr_inc(rptr_q);
            ram_cnt_d = ram_cnt_q - RC_WIDTH'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         ram_cnt_q <= '0;
         infl_q    <= '0;
         rr_q      <= RR_WR;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         ram_cnt_q <= ram_cnt_d;
         infl_q    <= infl_d;
         rr_q      <= rr_d;
      end
   end

   single_port_RAM #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(LB_DEPTH)) u_ram (
      .clk    (clk),
      .en_i   (gnt != GNT_NONE),
      .we_i   (gnt == GNT_WR),
      .addr_i ((gnt == GNT_WR) ? wptr_q : rptr_q),
      .din_i  (bus.wr_data),
      .dout_o (ram_dout)
   );

   assign pop = obuf_vld && bus.rd_ready;

   sp_ram_fifo_obuf #(.DATA_WIDTH(DATA_WIDTH)) u_obuf (
      .clk        (clk),
      .rst        (rst),
      .push_i     (infl_q[RAM_RD_LAT-1]),
      .push_dat_i (ram_dout),
      .pop_i      (pop),
      .head_o     (obuf_head),
      .vld_o      (obuf_vld),
      .occ_o      (occ)
   );

   assign bus.rd_data  = obuf_head;
   assign bus.rd_valid = obuf_vld;
   assign bus.count    = CNT_WIDTH'(ram_cnt_q) + CNT_WIDTH'(occ) + CNT_WIDTH'($countones(infl_q));
endmodule
